int_ctrl: RTL and testbench

//  Interrupt controller for the fetch stage. Collects NUM_SRC interrupt lines,

---
 rtl/int_ctrl.sv | 142 ++++++++++++++
 tb/tb_int_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl
//
// Interrupt controller for the fetch stage. Raw interrupt lines are
// edge-detected and latched into a pending register. The lowest-numbered
// pending source that is also enabled in the mask register wins arbitration.
// The winner is presented to fetch as a registered request (ipu_int/int_id).
// Only one interrupt is in service at a time:
//   IDLE -> REQ      (eligible source found)
//   REQ  -> SERVICE  (fetch acknowledged with int_ack)
//   SERVICE -> IDLE  (fetch retired the return-from-interrupt, int_done)
//
// Ports
//   clk        system clock, all state on posedge
//   rst        asynchronous, active-high reset
//   irq_in     raw interrupt lines, rising-edge sensitive
//   mask_wr    load mask_data into the mask register this cycle
//   mask_data  new mask value, 1 = source enabled
//   int_ack    fetch has taken the requested interrupt
//   int_done   fetch has seen the RTI opcode, handler finished
//   ipu_int    registered interrupt request to fetch
//   int_id     source being requested or serviced (kept in IDLE)
//   pending    pending-request register
//   busy       1 while in REQ or SERVICE
// ---------------------------------------------------------------------------
module int_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               ipu_int,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] pending_next;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    int_id_next;
    logic               ipu_int_next;

    // Edge detection and eligibility. Arbitration always sees the mask as it
    // stands before any write in the same cycle.
    always_comb begin
        rise     = irq_in & ~irq_prev;
        eligible = pending & mask;
    end

    // Fixed-priority pick: scanning downwards leaves the lowest set index.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Next-state and registered-output decode. int_id is frozen outside the
    // IDLE->REQ transition so late edges or mask writes cannot retarget a
    // request that fetch may already be acting on.
    always_comb begin
        state_next   = state;
        ipu_int_next = ipu_int;
        int_id_next  = int_id;
        ack_clr      = '0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_next   = REQ;
                    ipu_int_next = 1'b1;
                    int_id_next  = winner;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_next   = SERVICE;
                    ipu_int_next = 1'b0;
                    ack_clr      = NUM_SRC'(1) << int_id;
                end
            end
            SERVICE: begin
                if (int_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                ipu_int_next = 1'b0;
            end
        endcase
    end

    // A new rising edge in the acknowledge cycle is OR-ed in after the clear,
    // so the source stays pending and is requested again later.
    always_comb begin
        pending_next = (pending & ~ack_clr) | rise;
    end

    // State, request outputs, pending, mask and edge history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ipu_int  <= 1'b0;
            int_id   <= '0;
            pending  <= '0;
            mask     <= '1;
            irq_prev <= '0;
        end else begin
            state    <= state_next;
            ipu_int  <= ipu_int_next;
            int_id   <= int_id_next;
            pending  <= pending_next;
            irq_prev <= irq_in;
            if (mask_wr) begin
                mask <= mask_data;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_int_ctrl
//
// Self-checking bench for int_ctrl. A table of single-cycle vectors covers the
// basic request/ack/done flow, simultaneous sources and masking; hand-written
// sequences cover service-time edges, ack/rise collisions and async reset.
// A randomized phase compares every cycle against a behavioural model that
// tracks pending requests as per-source flags and the handshake as two flags.
// ---------------------------------------------------------------------------
module tb_int_ctrl;

    localparam int NS = 4;

    logic          clk;
    logic          rst;
    logic [NS-1:0] irq_in;
    logic          mask_wr;
    logic [NS-1:0] mask_data;
    logic          int_ack;
    logic          int_done;
    logic          ipu_int;
    logic [1:0]    int_id;
    logic [NS-1:0] pending;
    logic          busy;

    int pass_count;
    int check_count;

    int_ctrl #(.NUM_SRC(NS), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .int_ack   (int_ack),
        .int_done  (int_done),
        .ipu_int   (ipu_int),
        .int_id    (int_id),
        .pending   (pending),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] irq;
        logic          mw;
        logic [NS-1:0] md;
        logic          ack;
        logic          done;
        logic          e_ipu;
        logic [1:0]    e_id;
        logic [NS-1:0] e_pend;
        logic          e_busy;
    } vec_t;

    vec_t tbl[21];

    // Behavioural reference model state
    bit m_prev[NS];
    bit m_pend[NS];
    bit m_mask[NS];
    bit m_requesting;
    bit m_busy;
    int m_id;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_mask[i] = 1'b1;
        end
        m_requesting = 1'b0;
        m_busy       = 1'b0;
        m_id         = 0;
    endtask

    // One clock edge of the model, using the inputs seen at that edge.
    task automatic model_step(input logic [NS-1:0] irq, input logic mw,
                              input logic [NS-1:0] md, input logic ack,
                              input logic done);
        bit rose[NS];
        int pick;
        for (int i = 0; i < NS; i++) rose[i] = irq[i] && !m_prev[i];
        if (!m_busy) begin
            pick = -1;
            for (int i = NS - 1; i >= 0; i--)
                if (m_pend[i] && m_mask[i]) pick = i;
            if (pick >= 0) begin
                m_busy       = 1'b1;
                m_requesting = 1'b1;
                m_id         = pick;
            end
        end else if (m_requesting) begin
            if (ack) begin
                m_requesting = 1'b0;
                m_pend[m_id] = 1'b0;
            end
        end else if (done) begin
            m_busy = 1'b0;
        end
        for (int i = 0; i < NS; i++) if (rose[i]) m_pend[i] = 1'b1;
        if (mw) for (int i = 0; i < NS; i++) m_mask[i] = md[i];
        for (int i = 0; i < NS; i++) m_prev[i] = irq[i];
    endtask

    function automatic logic [NS-1:0] model_pending();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Drive one cycle of inputs, clock it, and land 1 time unit after the edge.
    task automatic applyStimulus(input logic [NS-1:0] irq, input logic mw,
                                 input logic [NS-1:0] md, input logic ack,
                                 input logic done);
        irq_in    = irq;
        mask_wr   = mw;
        mask_data = md;
        int_ack   = ack;
        int_done  = done;
        @(posedge clk);
        model_step(irq, mw, md, ack, done);
        #1;
    endtask

    task automatic check_one(input string name, input string field,
                             input logic [NS-1:0] got, input logic [NS-1:0] want);
        check_count++;
        if (got === want) pass_count++;
        else $display("[TB] FAIL %s.%s got %b want %b", name, field, got, want);
    endtask

    task automatic checkOutput(input string name, input logic e_ipu,
                               input logic [1:0] e_id, input logic [NS-1:0] e_pend,
                               input logic e_busy);
        check_one(name, "ipu_int", NS'(ipu_int), NS'(e_ipu));
        check_one(name, "int_id",  NS'(int_id),  NS'(e_id));
        check_one(name, "pending", pending,      e_pend);
        check_one(name, "busy",    NS'(busy),    NS'(e_busy));
    endtask

    task automatic hv(input string name, input logic [NS-1:0] irq, input logic ack,
                      input logic done, input logic e_ipu, input logic [1:0] e_id,
                      input logic [NS-1:0] e_pend, input logic e_busy);
        applyStimulus(irq, 1'b0, 4'b0000, ack, done);
        checkOutput(name, e_ipu, e_id, e_pend, e_busy);
    endtask

    initial begin
        pass_count = 0;
        check_count = 0;

        //          irq      mw    md       ack   done  ipu   id    pend     busy
        tbl[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0};
        tbl[1]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
        tbl[2]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[3]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0110, 1'b0};
        tbl[6]  = '{4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0110, 1'b1};
        tbl[7]  = '{4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0100, 1'b1};
        tbl[8]  = '{4'b0110, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0100, 1'b0};
        tbl[9]  = '{4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
        tbl[10] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        tbl[11] = '{4'b0110, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
        tbl[13] = '{4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
        tbl[14] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0001, 1'b0};
        tbl[15] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0001, 1'b0};
        tbl[16] = '{4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0001, 1'b0};
        tbl[17] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
        tbl[18] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[19] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[20] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};

        rst = 1'b1;
        irq_in = '0;
        mask_wr = 1'b0;
        mask_data = '0;
        int_ack = 1'b0;
        int_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            applyStimulus(tbl[i].irq, tbl[i].mw, tbl[i].md, tbl[i].ack, tbl[i].done);
            checkOutput($sformatf("tbl%0d", i), tbl[i].e_ipu, tbl[i].e_id,
                        tbl[i].e_pend, tbl[i].e_busy);
        end

        // Edge arriving while in service waits for int_done
        hv("svc_a", 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0);
        hv("svc_b", 4'b0100, 0, 0, 0, 2'd0, 4'b0100, 0);
        hv("svc_c", 4'b0100, 0, 0, 1, 2'd2, 4'b0100, 1);
        hv("svc_d", 4'b0100, 1, 0, 0, 2'd2, 4'b0000, 1);
        hv("svc_e", 4'b1100, 0, 0, 0, 2'd2, 4'b1000, 1);
        hv("svc_f", 4'b1100, 0, 0, 0, 2'd2, 4'b1000, 1);
        hv("svc_g", 4'b1100, 0, 1, 0, 2'd2, 4'b1000, 0);
        hv("svc_h", 4'b1100, 0, 0, 1, 2'd3, 4'b1000, 1);
        hv("svc_i", 4'b1100, 1, 0, 0, 2'd3, 4'b0000, 1);
        hv("svc_j", 4'b1100, 0, 1, 0, 2'd3, 4'b0000, 0);

        // New rise of the acknowledged source in the ack cycle stays pending
        hv("coll_a", 4'b0000, 0, 0, 0, 2'd3, 4'b0000, 0);
        hv("coll_b", 4'b0010, 0, 0, 0, 2'd3, 4'b0010, 0);
        hv("coll_c", 4'b0010, 0, 0, 1, 2'd1, 4'b0010, 1);
        hv("coll_d", 4'b0000, 0, 0, 1, 2'd1, 4'b0010, 1);
        hv("coll_e", 4'b0010, 1, 0, 0, 2'd1, 4'b0010, 1);
        hv("coll_f", 4'b0010, 0, 1, 0, 2'd1, 4'b0010, 0);
        hv("coll_g", 4'b0010, 0, 0, 1, 2'd1, 4'b0010, 1);
        hv("coll_h", 4'b0010, 1, 0, 0, 2'd1, 4'b0000, 1);
        hv("coll_i", 4'b0010, 0, 1, 0, 2'd1, 4'b0000, 0);

        // Asynchronous reset in SERVICE, then level-held line must not re-request
        hv("rst_a", 4'b0011, 0, 0, 0, 2'd1, 4'b0001, 0);
        hv("rst_b", 4'b0011, 0, 0, 1, 2'd0, 4'b0001, 1);
        hv("rst_c", 4'b0011, 1, 0, 0, 2'd0, 4'b0000, 1);
        #2;
        rst = 1'b1;
        irq_in = '0;
        int_ack = 1'b0;
        #1;
        checkOutput("rst_async", 1'b0, 2'd0, 4'b0000, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        hv("hold_a", 4'b0001, 0, 0, 0, 2'd0, 4'b0001, 0);
        hv("hold_b", 4'b0001, 0, 0, 1, 2'd0, 4'b0001, 1);
        hv("hold_c", 4'b0001, 1, 0, 0, 2'd0, 4'b0000, 1);
        hv("hold_d", 4'b0001, 0, 1, 0, 2'd0, 4'b0000, 0);
        hv("hold_e", 4'b0001, 0, 0, 0, 2'd0, 4'b0000, 0);
        hv("hold_f", 4'b0001, 0, 0, 0, 2'd0, 4'b0000, 0);
        hv("hold_g", 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0);
        hv("hold_h", 4'b0001, 0, 0, 0, 2'd0, 4'b0001, 0);
        hv("hold_i", 4'b0001, 0, 0, 1, 2'd0, 4'b0001, 1);

        // Randomized traffic against the reference model
        rst = 1'b1;
        irq_in = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic [NS-1:0] r_irq;
            r_irq = irq_in;
            for (int b = 0; b < NS; b++)
                if ($urandom_range(0, 3) == 0) r_irq[b] = ~r_irq[b];
            applyStimulus(r_irq, ($urandom_range(0, 9) == 0), NS'($urandom),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            checkOutput($sformatf("rand%0d", n), m_requesting, 2'(m_id),
                        model_pending(), m_busy);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
